// File: rtl/cbus_arbiter.sv
// rtl/cbus_arbiter.sv - round-robin burst arbiter sharing one cbus between cache masters
// Grants whole bursts; never interleaves beats of different masters.

package common;

  typedef enum logic [7:0] {
    MLEN1  = 8'd0,
    MLEN2  = 8'd1,
    MLEN4  = 8'd3,
    MLEN8  = 8'd7,
    MLEN16 = 8'd15
  } mlen_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED    = 2'd0,
    AXI_BURST_INCR     = 2'd1,
    AXI_BURST_WRAP     = 2'd2,
    AXI_BURST_RESERVED = 2'd3
  } axi_burst_type_t;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    logic [2:0]      size;
    logic [63:0]     addr;
    logic [7:0]      strobe;
    logic [63:0]     data;
    mlen_t           len;
    axi_burst_type_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage

module cbus_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  common::cbus_req_t  ireqs  [NUM_REQ],
  output common::cbus_resp_t oresps [NUM_REQ],
  output common::cbus_req_t  oreq,
  input  common::cbus_resp_t iresp
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic             found;
  logic [IDX_W-1:0] found_idx;
  logic             burst_done;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= int'(NUM_REQ)) s = s - int'(NUM_REQ);
    return IDX_W'(s);
  endfunction

  // Scan from the highest offset down so the candidate closest to ptr wins.
  always_comb begin
    found     = 1'b0;
    found_idx = ptr_q;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      if (ireqs[wrap_add(ptr_q, k)].valid) begin
        found     = 1'b1;
        found_idx = wrap_add(ptr_q, k);
      end
    end
  end

  assign burst_done = iresp.ready && iresp.last;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = found_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (burst_done) begin
          state_d = IDLE;
          ptr_d   = wrap_add(sel_q, 1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Routing is purely combinational so per-beat data/strobe reach the bridge same cycle.
  always_comb begin
    oreq = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      oresps[i] = '0;
    end
    if (state_q == BUSY) begin
      oreq          = ireqs[sel_q];
      oresps[sel_q] = iresp;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

`ifndef SYNTHESIS
  // Granted master must keep valid asserted until its burst completes.
  granted_valid_held: assert property (
    @(posedge clk) disable iff (!resetn) (state_q == BUSY) |-> ireqs[sel_q].valid
  );
`endif

endmodule

// File: tb/tb_cbus_arbiter.sv
// tb/tb_cbus_arbiter.sv - directed self-checking bench for cbus_arbiter
module tb_cbus_arbiter;
  import common::*;

  localparam logic [63:0] A0 = 64'h0000_0000_8000_0000;
  localparam logic [63:0] A1 = 64'h0000_0000_8000_1000;

  logic       clk = 1'b0;
  logic       resetn;
  cbus_req_t  ireqs  [2];
  cbus_resp_t oresps [2];
  cbus_req_t  oreq;
  cbus_resp_t iresp;

  int n_checks = 0;
  int n_fail   = 0;

  cbus_arbiter #(.NUM_REQ(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .ireqs  (ireqs),
    .oresps (oresps),
    .oreq   (oreq),
    .iresp  (iresp)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic [63:0] addr, input mlen_t len, input logic wr);
    ireqs[m]          = '0;
    ireqs[m].valid    = 1'b1;
    ireqs[m].is_write = wr;
    ireqs[m].size     = 3'd3;
    ireqs[m].addr     = addr;
    ireqs[m].strobe   = wr ? 8'hff : 8'h00;
    ireqs[m].len      = len;
    ireqs[m].burst    = AXI_BURST_INCR;
  endtask

  // Called one cycle after the grant edge; drives every beat and checks routing.
  task automatic run_txn(input string tag, input int m, input int beats, input logic [63:0] exp_addr);
    cbus_resp_t r;
    for (int b = 0; b < beats; b++) begin
      r       = '0;
      r.ready = 1'b1;
      r.last  = (b == beats - 1);
      r.data  = 64'hA5A5_0000_0000_0000 | 64'(b);
      iresp   = r;
      #1;
      check_eq({tag, "_valid"}, 256'(oreq.valid), 256'(1));
      check_eq({tag, "_addr"}, 256'(oreq.addr), 256'(exp_addr));
      check_eq({tag, "_resp_sel"}, 256'(oresps[m]), 256'(r));
      check_eq({tag, "_resp_other"}, 256'(oresps[1-m]), 256'(0));
      @(posedge clk);
      #1;
      iresp = '0;
    end
  endtask

  initial begin
    cbus_resp_t r;
    logic [63:0] wdata [4];
    wdata[0] = 64'h1111_2222_3333_4444;
    wdata[1] = 64'h5555_6666_7777_8888;
    wdata[2] = 64'h9999_aaaa_bbbb_cccc;
    wdata[3] = 64'hdddd_eeee_ffff_0000;

    resetn   = 1'b0;
    iresp    = '0;
    ireqs[0] = '0;
    ireqs[1] = '0;

    // 1: reset with master 0 requesting
    set_req(0, A0, MLEN16, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("rst_oreq_valid", 256'(oreq.valid), 256'(0));
      check_eq("rst_oresp0", 256'(oresps[0]), 256'(0));
      check_eq("rst_oresp1", 256'(oresps[1]), 256'(0));
    end
    ireqs[0] = '0;
    resetn   = 1'b1;
    step();

    // 2: lone I-cache 16-beat read
    set_req(0, A0, MLEN16, 1'b0);
    #1;
    check_eq("t2_bubble", 256'(oreq.valid), 256'(0));
    step();
    check_eq("t2_len", 256'(oreq.len), 256'(MLEN16));
    run_txn("t2", 0, 16, A0);
    ireqs[0] = '0;
    #1;
    check_eq("t2_idle_after", 256'(oreq), 256'(0));
    step();

    // 3: both request after reset, master 0 first, one bubble, then master 1
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    set_req(0, A0, MLEN4, 1'b0);
    set_req(1, A1, MLEN2, 1'b0);
    #1;
    check_eq("t3_bubble0", 256'(oreq.valid), 256'(0));
    step();
    run_txn("t3_m0", 0, 4, A0);
    ireqs[0] = '0;
    #1;
    check_eq("t3_bubble1", 256'(oreq.valid), 256'(0));
    step();
    run_txn("t3_m1", 1, 2, A1);
    ireqs[1] = '0;

    // 4: both continuously requesting, grants alternate 0,1,0,1,0,1
    set_req(0, A0, MLEN2, 1'b0);
    set_req(1, A1, MLEN2, 1'b0);
    for (int t = 0; t < 6; t++) begin
      #1;
      check_eq("t4_bubble", 256'(oreq.valid), 256'(0));
      step();
      run_txn("t4_rr", t % 2, 2, (t % 2 == 0) ? A0 : A1);
    end
    ireqs[0] = '0;
    ireqs[1] = '0;
    step();

    // 5: D-cache write burst with changing data, master 0 raised mid-burst
    set_req(1, A1, MLEN4, 1'b1);
    ireqs[1].data = wdata[0];
    step();
    for (int b = 0; b < 4; b++) begin
      ireqs[1].data = wdata[b];
      if (b == 1) set_req(0, A0, MLEN1, 1'b0);
      r       = '0;
      r.ready = 1'b1;
      r.last  = (b == 3);
      iresp   = r;
      #1;
      check_eq("t5_data", 256'(oreq.data), 256'(wdata[b]));
      check_eq("t5_wr", 256'(oreq.is_write), 256'(1));
      check_eq("t5_addr", 256'(oreq.addr), 256'(A1));
      check_eq("t5_resp1", 256'(oresps[1]), 256'(r));
      check_eq("t5_resp0", 256'(oresps[0]), 256'(0));
      step();
      iresp = '0;
    end
    ireqs[1] = '0;
    #1;
    check_eq("t5_bubble", 256'(oreq.valid), 256'(0));
    step();
    run_txn("t5_single", 0, 1, A0);
    ireqs[0] = '0;
    step();

    // 6: reset on beat 2 of an 8-beat burst, then pending master 1 wins
    set_req(0, A0, MLEN8, 1'b0);
    step();
    for (int b = 0; b < 2; b++) begin
      r       = '0;
      r.ready = 1'b1;
      iresp   = r;
      #1;
      check_eq("t6_beat_valid", 256'(oreq.valid), 256'(1));
      step();
    end
    iresp.ready = 1'b1;
    resetn      = 1'b0;
    step();
    check_eq("t6_rst_oreq", 256'(oreq), 256'(0));
    check_eq("t6_rst_oresp0", 256'(oresps[0]), 256'(0));
    iresp    = '0;
    resetn   = 1'b1;
    ireqs[0] = '0;
    set_req(1, A1, MLEN2, 1'b0);
    #1;
    check_eq("t6_idle", 256'(oreq.valid), 256'(0));
    step();
    run_txn("t6_m1", 1, 2, A1);
    ireqs[1] = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
